// File: rtl/handshaking_xbar_pkg.sv
// ============================================================================
// Package  : handshaking_xbar_pkg
// Purpose  : Routing constants and default width shared by the 2x2 crossbars.
// Revision : 1.0
// ============================================================================
`default_nettype none

package handshaking_xbar_pkg;

  localparam logic ID_M1  = 1'b0;
  localparam logic ID_M2  = 1'b1;
  localparam logic SRC_S1 = 1'b0;
  localparam logic SRC_S2 = 1'b1;

  localparam int DEFAULT_DATA_W = 8;

endpackage

`default_nettype wire

// File: rtl/resp_arb_slot.sv
// ============================================================================
// Module   : resp_arb_slot
// Purpose  : One master's response slot: request decode, round-robin pick, output register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module resp_arb_slot
  import handshaking_xbar_pkg::*;
#(
  parameter int   DATA_W    = DEFAULT_DATA_W,
  parameter logic MASTER_ID = ID_M1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_s1_i,
  input  logic              id_s1_i,
  input  logic              valid_s1_i,
  input  logic [DATA_W-1:0] data_s2_i,
  input  logic              id_s2_i,
  input  logic              valid_s2_i,
  output logic              gnt_s1_o,
  output logic              gnt_s2_o,
  output logic [DATA_W-1:0] data_o,
  output logic              src_o,
  output logic              valid_o,
  input  logic              ready_i
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              src_q, src_d;
  logic              valid_q, valid_d;
  logic              ptr_q, ptr_d;
  logic              req_s1, req_s2, can_accept;

  always_comb begin
    req_s1     = valid_s1_i && (id_s1_i == MASTER_ID);
    req_s2     = valid_s2_i && (id_s2_i == MASTER_ID);
    // Full register may still accept when the master drains it this cycle.
    can_accept = !rst && (!valid_q || ready_i);
    gnt_s1_o   = req_s1 && (!req_s2 || (ptr_q == SRC_S1)) && can_accept;
    gnt_s2_o   = req_s2 && (!req_s1 || (ptr_q == SRC_S2)) && can_accept;

    data_d  = data_q;
    src_d   = src_q;
    ptr_d   = ptr_q;
    valid_d = valid_q && !ready_i;
    if (gnt_s1_o) begin
      data_d  = data_s1_i;
      src_d   = SRC_S1;
      valid_d = 1'b1;
      ptr_d   = SRC_S2;
    end else if (gnt_s2_o) begin
      data_d  = data_s2_i;
      src_d   = SRC_S2;
      valid_d = 1'b1;
      ptr_d   = SRC_S1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      src_q   <= SRC_S1;
      valid_q <= 1'b0;
      ptr_q   <= SRC_S1;
    end else begin
      data_q  <= data_d;
      src_q   <= src_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign data_o  = data_q;
  assign src_o   = src_q;
  assign valid_o = valid_q;

endmodule

`default_nettype wire

// File: rtl/handshaking_resp_xbar_2x2.sv
// ============================================================================
// Module   : handshaking_resp_xbar_2x2
// Purpose  : Registered 2x2 response crossbar routing slave responses to masters by ID.
//            HANDSHAKING_RESP_XBAR_CNT_EN adds per-master 16-bit handshake counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module handshaking_resp_xbar_2x2
  import handshaking_xbar_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_out_s1,
  input  logic              id_out_s1,
  input  logic              valid_out_s1,
  output logic              ready_in_s1,
  input  logic [DATA_W-1:0] data_out_s2,
  input  logic              id_out_s2,
  input  logic              valid_out_s2,
  output logic              ready_in_s2,
  output logic [DATA_W-1:0] data_in_m1,
  output logic              src_in_m1,
  output logic              valid_in_m1,
  input  logic              ready_out_m1,
  output logic [DATA_W-1:0] data_in_m2,
  output logic              src_in_m2,
  output logic              valid_in_m2,
  input  logic              ready_out_m2
`ifdef HANDSHAKING_RESP_XBAR_CNT_EN
  ,
  output logic [15:0]       cnt_m1,
  output logic [15:0]       cnt_m2
`endif
);

  logic gnt_s1_m1, gnt_s2_m1, gnt_s1_m2, gnt_s2_m2;

  resp_arb_slot #(.DATA_W(DATA_W), .MASTER_ID(ID_M1)) u_slot_m1 (
    .clk       (clk),
    .rst       (rst),
    .data_s1_i (data_out_s1),
    .id_s1_i   (id_out_s1),
    .valid_s1_i(valid_out_s1),
    .data_s2_i (data_out_s2),
    .id_s2_i   (id_out_s2),
    .valid_s2_i(valid_out_s2),
    .gnt_s1_o  (gnt_s1_m1),
    .gnt_s2_o  (gnt_s2_m1),
    .data_o    (data_in_m1),
    .src_o     (src_in_m1),
    .valid_o   (valid_in_m1),
    .ready_i   (ready_out_m1)
  );

  resp_arb_slot #(.DATA_W(DATA_W), .MASTER_ID(ID_M2)) u_slot_m2 (
    .clk       (clk),
    .rst       (rst),
    .data_s1_i (data_out_s1),
    .id_s1_i   (id_out_s1),
    .valid_s1_i(valid_out_s1),
    .data_s2_i (data_out_s2),
    .id_s2_i   (id_out_s2),
    .valid_s2_i(valid_out_s2),
    .gnt_s1_o  (gnt_s1_m2),
    .gnt_s2_o  (gnt_s2_m2),
    .data_o    (data_in_m2),
    .src_o     (src_in_m2),
    .valid_o   (valid_in_m2),
    .ready_i   (ready_out_m2)
  );

  // A slot only grants a slave whose ID targets it, so at most one term is set.
  assign ready_in_s1 = gnt_s1_m1 | gnt_s1_m2;
  assign ready_in_s2 = gnt_s2_m1 | gnt_s2_m2;

`ifdef HANDSHAKING_RESP_XBAR_CNT_EN
  logic [15:0] cnt_m1_q, cnt_m2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_m1_q <= '0;
      cnt_m2_q <= '0;
    end else begin
      if (valid_in_m1 && ready_out_m1) cnt_m1_q <= cnt_m1_q + 16'd1;
      if (valid_in_m2 && ready_out_m2) cnt_m2_q <= cnt_m2_q + 16'd1;
    end
  end

  assign cnt_m1 = cnt_m1_q;
  assign cnt_m2 = cnt_m2_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_handshaking_resp_xbar_2x2.sv
// ============================================================================
// Module   : tb_handshaking_resp_xbar_2x2
// Purpose  : Directed and random checks of the response crossbar against a reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_handshaking_resp_xbar_2x2;

  logic       clk;
  logic       rst;
  logic [7:0] d   [2];
  logic       id  [2];
  logic       v   [2];
  logic       rdy [2];
  logic       ready_in_s1, ready_in_s2;
  logic [7:0] data_in_m1, data_in_m2;
  logic       src_in_m1, src_in_m2, valid_in_m1, valid_in_m2;
`ifdef HANDSHAKING_RESP_XBAR_CNT_EN
  logic [15:0] cnt_m1, cnt_m2;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model state: one buffered response per master plus its tie-break preference.
  logic       m_full [2];
  logic [7:0] m_data [2];
  logic       m_src  [2];
  logic       m_pref [2];
  int         m_cnt  [2];
  logic       last_acc [2];
  logic [7:0] got_m1 [$];

  handshaking_resp_xbar_2x2 #(.DATA_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .data_out_s1 (d[0]),
    .id_out_s1   (id[0]),
    .valid_out_s1(v[0]),
    .ready_in_s1 (ready_in_s1),
    .data_out_s2 (d[1]),
    .id_out_s2   (id[1]),
    .valid_out_s2(v[1]),
    .ready_in_s2 (ready_in_s2),
    .data_in_m1  (data_in_m1),
    .src_in_m1   (src_in_m1),
    .valid_in_m1 (valid_in_m1),
    .ready_out_m1(rdy[0]),
    .data_in_m2  (data_in_m2),
    .src_in_m2   (src_in_m2),
    .valid_in_m2 (valid_in_m2),
    .ready_out_m2(rdy[1])
`ifdef HANDSHAKING_RESP_XBAR_CNT_EN
    ,
    .cnt_m1      (cnt_m1),
    .cnt_m2      (cnt_m2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: check slave readies before the edge, advance the model, check master outputs after.
  task automatic step();
    int  win [2];
    logic r0, r1, can;
    logic hs [2];
    #1;
    for (int m = 0; m < 2; m++) begin
      r0  = v[0] && (32'(id[0]) == m);
      r1  = v[1] && (32'(id[1]) == m);
      can = !rst && (!m_full[m] || rdy[m]);
      if (r0 && r1)  win[m] = int'(m_pref[m]);
      else if (r0)   win[m] = 0;
      else if (r1)   win[m] = 1;
      else           win[m] = -1;
      if (!can) win[m] = -1;
      hs[m] = !rst && m_full[m] && rdy[m];
    end
    last_acc[0] = (win[0] == 0) || (win[1] == 0);
    last_acc[1] = (win[0] == 1) || (win[1] == 1);
    chk("ready_s1", 32'(ready_in_s1), 32'(last_acc[0]));
    chk("ready_s2", 32'(ready_in_s2), 32'(last_acc[1]));
    if (valid_in_m1 && rdy[0]) got_m1.push_back(data_in_m1);
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        m_full[m] = 1'b0; m_data[m] = 8'h00; m_src[m] = 1'b0; m_pref[m] = 1'b0; m_cnt[m] = 0;
      end else begin
        if (win[m] >= 0) begin
          m_full[m] = 1'b1;
          m_data[m] = d[win[m]];
          m_src[m]  = (win[m] == 1);
          m_pref[m] = (win[m] == 0);
        end else if (hs[m]) begin
          m_full[m] = 1'b0;
        end
        if (hs[m]) m_cnt[m] = (m_cnt[m] + 1) % 65536;
      end
    end
    #1;
    chk("valid_m1", 32'(valid_in_m1), 32'(m_full[0]));
    chk("valid_m2", 32'(valid_in_m2), 32'(m_full[1]));
    if (m_full[0] || rst) begin
      chk("data_m1", 32'(data_in_m1), 32'(m_data[0]));
      chk("src_m1",  32'(src_in_m1),  32'(m_src[0]));
    end
    if (m_full[1] || rst) begin
      chk("data_m2", 32'(data_in_m2), 32'(m_data[1]));
      chk("src_m2",  32'(src_in_m2),  32'(m_src[1]));
    end
`ifdef HANDSHAKING_RESP_XBAR_CNT_EN
    chk("cnt_m1", 32'(cnt_m1), 32'(m_cnt[0]));
    chk("cnt_m2", 32'(cnt_m2), 32'(m_cnt[1]));
`endif
    @(negedge clk);
  endtask

  task automatic drive(input int s, input logic vv, input logic ii, input logic [7:0] dd);
    v[s] = vv; id[s] = ii; d[s] = dd;
  endtask

  initial begin
    logic [7:0] exp_stream [8];
    int i1, i2;
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      drive(s, 1'b1, 1'b0, 8'hFF); rdy[s] = 1'b1;
      m_full[s] = 1'b0; m_data[s] = 8'h00; m_src[s] = 1'b0; m_pref[s] = 1'b0; m_cnt[s] = 0;
    end
    @(negedge clk);

    // Reset held with every slave valid
    step(); step();
    chk("rst_data_m1", 32'(data_in_m1), 32'h0);
    chk("rst_data_m2", 32'(data_in_m2), 32'h0);
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 8'h00); drive(1, 1'b0, 1'b0, 8'h00);
    step();

    // Single response, one-cycle latency, one-cycle valid
    drive(0, 1'b1, 1'b0, 8'h20);
    step();
    drive(0, 1'b0, 1'b0, 8'h00);
    chk("t2_data", 32'(data_in_m1), 32'h20);
    chk("t2_valid", 32'(valid_in_m1), 32'h1);
    step();
    chk("t2_valid_drop", 32'(valid_in_m1), 32'h0);

    // Crossed parallel transfers
    drive(0, 1'b1, 1'b1, 8'h30); drive(1, 1'b1, 1'b0, 8'h40);
    step();
    drive(0, 1'b0, 1'b0, 8'h00); drive(1, 1'b0, 1'b0, 8'h00);
    chk("t3_m2", 32'({valid_in_m2, src_in_m2, data_in_m2}), 32'({1'b1, 1'b0, 8'h30}));
    chk("t3_m1", 32'({valid_in_m1, src_in_m1, data_in_m1}), 32'({1'b1, 1'b1, 8'h40}));
    step();

    // Reset, then two streams to M1 interleave S1 first
    rst = 1'b1; step(); rst = 1'b0;
    got_m1.delete();
    i1 = 0; i2 = 0;
    for (int c = 0; c < 10; c++) begin
      drive(0, i1 < 4, 1'b0, 8'h20 + 8'(i1));
      drive(1, i2 < 4, 1'b0, 8'hA0 + 8'(i2));
      step();
      if (last_acc[0]) i1++;
      if (last_acc[1]) i2++;
    end
    exp_stream = '{8'h20, 8'hA0, 8'h21, 8'hA1, 8'h22, 8'hA2, 8'h23, 8'hA3};
    chk("t4_count", 32'(got_m1.size()), 32'd8);
    for (int k = 0; k < 8; k++)
      if (k < got_m1.size()) chk("t4_order", 32'(got_m1[k]), 32'(exp_stream[k]));

    // Backpressure on M2 holds output stable and blocks the next response
    drive(0, 1'b0, 1'b0, 8'h00);
    drive(1, 1'b1, 1'b1, 8'h55); rdy[1] = 1'b0;
    step();
    drive(1, 1'b1, 1'b1, 8'h56);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("t5_hold", 32'({valid_in_m2, data_in_m2}), 32'({1'b1, 8'h55}));
      chk("t5_block", 32'(ready_in_s2), 32'h0);
    end
    rdy[1] = 1'b1;
    step();
    drive(1, 1'b0, 1'b0, 8'h00);
    chk("t5_next", 32'({valid_in_m2, data_in_m2}), 32'({1'b1, 8'h56}));
    step();
    chk("t5_empty", 32'(valid_in_m2), 32'h0);

    // Reset discards a stalled response; tie then goes to S1
    drive(0, 1'b1, 1'b0, 8'h77); rdy[0] = 1'b0;
    step();
    drive(0, 1'b0, 1'b0, 8'h00);
    step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("t6_flush", 32'(valid_in_m1), 32'h0);
    rdy[0] = 1'b1;
    drive(0, 1'b1, 1'b0, 8'h11); drive(1, 1'b1, 1'b0, 8'h22);
    step();
    chk("t6_tie_src", 32'({valid_in_m1, src_in_m1, data_in_m1}), 32'({1'b1, 1'b0, 8'h11}));
    drive(0, 1'b0, 1'b0, 8'h00); drive(1, 1'b0, 1'b0, 8'h00);
    step();

    // Random traffic; slaves hold their response until it is accepted
    last_acc[0] = 1'b1; last_acc[1] = 1'b1;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 79) == 0);
      for (int s = 0; s < 2; s++) begin
        if (!v[s] || last_acc[s])
          drive(s, $urandom_range(0, 3) != 0, 1'($urandom), 8'($urandom));
        rdy[s] = ($urandom_range(0, 3) != 0);
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/handshaking_resp_xbar_2x2.md
Name: handshaking_resp_xbar_2x2

Overview:
Return-path companion to the 2x2 handshaking request crossbar. Routes responses from slaves S1/S2 back to masters M1/M2 using a destination ID carried with each response. Each master output has its own round-robin arbiter and a one-entry output register, so slave valid never reaches a master combinationally. The block sits between the slave response ports and the master response ports.

Parameters:
DATA_W, 8, response data width.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst  input  1  synchronous reset, active-high.
data_out_s1  input  DATA_W  S1 response data.
id_out_s1  input  1  S1 destination: 0 = M1, 1 = M2.
valid_out_s1  input  1  S1 response valid.
ready_in_s1  output  1  crossbar accepts S1 response.
data_out_s2 / id_out_s2 / valid_out_s2 / ready_in_s2  same as S1, for S2.
data_in_m1  output  DATA_W  response data to M1.
src_in_m1  output  1  originating slave: 0 = S1, 1 = S2.
valid_in_m1  output  1  response valid to M1.
ready_out_m1  input  1  M1 accepts the response.
data_in_m2 / src_in_m2 / valid_in_m2 / ready_out_m2  same as M1, for M2.

Behaviour:
- Reset (rst=1 at a clk edge): valid_in_m*=0, data_in_m*=0, src_in_m*=0, both round-robin pointers select S1. ready_in_s* is 0 while rst=1. Register contents are discarded when reset is asserted mid-transfer.
- Per-master slot m: req_s = valid_out_s && (id_out_s == m). The slot can accept when its register is empty, or when it is full and ready_out_m=1 (drain and refill in the same cycle).
- Arbitration:
  - A single request is granted directly.
  - If both slaves request, the slot grants the slave selected by its pointer.
  - After any accepted grant, the pointer moves to the other slave. It does not move without a handshake.
- ready_in_s = grant to s by slot[id_out_s] && that slot can accept. ready_in_s is combinational from valid, id and ready_out_m. It is 0 when valid_out_s=0.
- On the slave handshake (valid_out_s && ready_in_s):
  - The slot register loads {data_out_s, src=s}.
  - valid_in_m is set on the next cycle, giving a latency of 1 cycle.
- The register clears when valid_in_m && ready_out_m and no new load occurs. Sustained throughput is 1 response per cycle per master.
- While valid_in_m=1 and ready_out_m=0, data_in_m and src_in_m hold stable. valid never drops without a handshake.
- Both slaves may target different masters in the same cycle with no interaction, which gives 2 transfers per cycle.
- Slaves must hold data and id while valid && !ready. The crossbar does not check this.
- There is no combinational path from valid_out_s to valid_in_m. There is a combinational path from ready_out_m to ready_in_s.

Optional Feature:
HANDSHAKING_RESP_XBAR_CNT_EN
- Defined:
  - Adds outputs cnt_m1 and cnt_m2, each 16 bits.
  - Each counter increments on its master's handshake (valid_in_m && ready_out_m).
  - Counters wrap from 0xFFFF to 0 and reset to 0.
- Undefined: the counter ports and logic are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package/header `handshaking_xbar_pkg`:
  - Constants ID_M1=0, ID_M2=1, SRC_S1=0, SRC_S2=1.
  - Default DATA_W.
  - The request crossbar uses the same constants.
- Sub-module `resp_arb_slot`, instantiated twice with parameter MASTER_ID:
  - Contains the request decode, round-robin pointer, grant logic and output register.
  - The top level only ORs the per-slot grant/ready back to each slave.

Test Plan:
1. Reset with rst=1 for 2 cycles and all valid_out_s*=1 -> ready_in_s*=0, valid_in_m*=0 and data_in_m*=0 throughout.
2. S1 sends 0x20 with id=0 and M1 ready=1 -> ready_in_s1=1. Next cycle valid_in_m1=1, data_in_m1=0x20, src_in_m1=0 for exactly 1 cycle.
3. Simultaneously S1 sends 0x30 (id=1) and S2 sends 0x40 (id=0), both masters ready -> next cycle M2 gets 0x30 (src=0) and M1 gets 0x40 (src=1) in the same cycle.
4. S1 streams 0x20–0x23 and S2 streams 0xA0–0xA3, all id=0, M1 ready=1 -> M1 receives 0x20,0xA0,0x21,0xA1,... back-to-back with no bubbles, S1 first after reset.
5. S2 sends 0x55 to M2 with ready_out_m2=0 for 4 cycles:
   - valid_in_m2=1 and data_in_m2=0x55 hold stable.
   - ready_in_s2=0 for a second response 0x56.
   - When M2 raises ready, 0x55 and then 0x56 are delivered on consecutive cycles.
6. Assert rst while M1 holds 0x77 unaccepted -> valid_in_m1=0 next cycle. After release, the pointer again grants S1 first on a tie.
